// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of digit steps needed to cover a full operand.
   function automatic int steps(input int width, input int digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/adder_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit.
module adder_digit
   import serial_adder_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             carry_msb
);

   logic [DIGIT:0] carry;

   always_comb begin
      carry    = '0;
      sum      = '0;
      carry[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry[i];
         carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout      = carry[DIGIT];
   assign carry_msb = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder with valid/ready handshakes, LSB digit first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = steps(WIDTH, DIGIT);
   localparam int CNT_W = $clog2(STEPS + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             carry;

   logic [DIGIT-1:0] d_sum;
   logic             d_cout;
   logic             d_carry_msb;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

   adder_digit #(.DIGIT(DIGIT)) u_digit (
      .a         (a_sh[DIGIT-1:0]),
      .b         (b_sh[DIGIT-1:0]),
      .cin       (carry),
      .sum       (d_sum),
      .cout      (d_cout),
      .carry_msb (d_carry_msb)
   );

   // New digits enter at the top so the LSB digit ends up at bit 0 after STEPS shifts.
   generate
      if (DIGIT == WIDTH) begin : g_single
         assign acc_next = d_sum;
      end else begin : g_multi
         assign acc_next = {d_sum, acc[WIDTH-1:DIGIT]};
      end
   endgenerate

`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub | cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   assign in_ready  = (state == IDLE) && !reset;
   assign out_valid = (state == DONE);

   // FSM, datapath shift registers and carry flop; results latch on the final step only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         carry <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b_load;
                  carry <= carry_load;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               carry <= d_cout;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST_STEP) begin
                  sum   <= acc_next;
                  cout  <= d_cout;
                  ovf   <= d_carry_msb ^ d_cout;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (8x1 and 16x4 instances).
module tb_serial_adder;

   logic        clk;
   logic        reset;

   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  sum;
   logic        cout;
   logic        ovf;

   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        cin16;
   logic        sub16;
   logic        out_valid16;
   logic        out_ready16;
   logic [15:0] sum16;
   logic        cout16;
   logic        ovf16;

   int checks;
   int errors;
   int lat;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .a         (a16),
      .b         (b16),
      .cin       (cin16),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub16),
`endif
      .out_valid (out_valid16),
      .out_ready (out_ready16),
      .sum       (sum16),
      .cout      (cout16),
      .ovf       (ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents operands for one accept edge on the 8-bit instance.
   task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                input logic vcin, input logic vsub);
      checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
      a        = va;
      b        = vb;
      cin      = vcin;
      sub      = vsub;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a        = 8'h00;
      b        = 8'h00;
      cin      = 1'b0;
   endtask

   task automatic waitResult(input string tag, input int exp_lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic checkResult(input string tag, input logic [7:0] es,
                              input logic ec, input logic eo);
      checkOutput({tag, "_sum"}, 32'(sum), 32'(es));
      checkOutput({tag, "_cout"}, 32'(cout), 32'(ec));
      checkOutput({tag, "_ovf"}, 32'(ovf), 32'(eo));
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      a           = 8'h00;
      b           = 8'h00;
      cin         = 1'b0;
      sub         = 1'b0;
      out_ready   = 1'b1;
      in_valid16  = 1'b0;
      a16         = 16'h0000;
      b16         = 16'h0000;
      cin16       = 1'b0;
      sub16       = 1'b0;
      out_ready16 = 1'b1;

      step();
      step();
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkResult("reset", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      checkOutput("release_in_ready", 32'(in_ready), 32'd1);

      applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
      checkOutput("run_in_ready", 32'(in_ready), 32'd0);
      waitResult("add_5a_3c", 8);
      checkResult("add_5a_3c", 8'h96, 1'b0, 1'b1);
      step();
      checkOutput("back_idle_in_ready", 32'(in_ready), 32'd1);
      checkOutput("back_idle_out_valid", 32'(out_valid), 32'd0);
      checkOutput("hold_after_done_sum", 32'(sum), 32'h96);

      applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0);
      waitResult("add_ff_00_c1", 8);
      checkResult("add_ff_00_c1", 8'h00, 1'b1, 1'b0);
      step();

      applyStimulus(8'h80, 8'h80, 1'b0, 1'b0);
      waitResult("add_80_80", 8);
      checkResult("add_80_80", 8'h00, 1'b1, 1'b1);
      step();

      // Backpressure: result held while a pending input waits.
      out_ready = 1'b0;
      applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
      waitResult("bp_first", 8);
      a        = 8'h11;
      b        = 8'h22;
      cin      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         checkResult("bp_hold", 8'h46, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      step();
      checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
      checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0;
      checkOutput("bp_pending_accepted", 32'(in_ready), 32'd0);
      checkOutput("bp_sum_held_in_run", 32'(sum), 32'h46);
      waitResult("bp_second", 8);
      checkResult("bp_second", 8'h33, 1'b0, 1'b0);
      step();

      // Reset asserted during the third RUN cycle.
      applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
      step();
      step();
      reset = 1'b1;
      step();
      checkOutput("midrun_reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrun_reset_in_ready", 32'(in_ready), 32'd0);
      checkResult("midrun_reset", 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      checkOutput("midrun_release_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(8'h01, 8'h01, 1'b0, 1'b0);
      waitResult("after_reset", 8);
      checkResult("after_reset", 8'h02, 1'b0, 1'b0);
      step();

`ifdef SERIAL_ADDER_SUB_EN
      applyStimulus(8'h05, 8'h07, 1'b0, 1'b1);
      waitResult("sub_05_07", 8);
      checkResult("sub_05_07", 8'hFE, 1'b0, 1'b0);
      step();
      applyStimulus(8'h07, 8'h05, 1'b0, 1'b1);
      waitResult("sub_07_05", 8);
      checkResult("sub_07_05", 8'h02, 1'b1, 1'b0);
      step();
`endif

      // 16-bit, 4-bit digit instance.
      checkOutput("w16_in_ready", 32'(in_ready16), 32'd1);
      a16        = 16'h7FFF;
      b16        = 16'h0001;
      cin16      = 1'b0;
      in_valid16 = 1'b1;
      step();
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 50) begin
         step();
         lat++;
      end
      checkOutput("w16_latency", 32'(lat), 32'd4);
      checkOutput("w16_sum", 32'(sum16), 32'h8000);
      checkOutput("w16_cout", 32'(cout16), 32'd0);
      checkOutput("w16_ovf", 32'(ovf16), 32'd1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
